// File: rtl/lsu_data_mem_pkg.sv
// lsu_pkg: shared constants for the MEM-stage data memory.
//   - BHW size encodings (same as the control unit's i_BHW_CU[1:0])
//   - BHW unsigned-flag bit index
//   - FSM state encoding
//   - bhw_err(): illegal-size / misalignment check
package lsu_pkg;

   localparam logic [1:0] BHW_BYTE     = 2'b00;
   localparam logic [1:0] BHW_HALF     = 2'b01;
   localparam logic [1:0] BHW_WORD     = 2'b11;
   localparam int         BHW_UNSIGNED = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // 1 when the size code is illegal (2'b10) or the access is misaligned
   function automatic logic bhw_err(input logic [1:0] size, input logic [1:0] low_addr);
      return (size == 2'b10) ||
             (size == BHW_HALF && low_addr[0]) ||
             (size == BHW_WORD && low_addr != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// lsu_data_mem_if: request/response bus plus debug read port of lsu_data_mem.
//   master: MEM stage / debug unit (drives i_* signals)
//   slave : lsu_data_mem (drives o_* signals)
interface lsu_data_mem_if #(
   parameter int NB_WIDTH = 32,
   parameter int NB_ADDR  = 9
);
   logic                 i_req_valid;
   logic                 o_req_ready;
   logic [NB_WIDTH-1:0]  i_mem_addr;
   logic [NB_WIDTH-1:0]  i_mem_data;
   logic                 i_mem_read_CU;
   logic                 i_mem_write_CU;
   logic [2:0]           i_BHW_CU;
   logic                 o_rsp_valid;
   logic [NB_WIDTH-1:0]  o_read_data;
   logic                 o_err;
   logic [NB_ADDR-3:0]   i_dbg_addr;
   logic [NB_WIDTH-1:0]  o_dbg_data;

   modport master (
      output i_req_valid, i_mem_addr, i_mem_data, i_mem_read_CU, i_mem_write_CU,
             i_BHW_CU, i_dbg_addr,
      input  o_req_ready, o_rsp_valid, o_read_data, o_err, o_dbg_data
   );

   modport slave (
      input  i_req_valid, i_mem_addr, i_mem_data, i_mem_read_CU, i_mem_write_CU,
             i_BHW_CU, i_dbg_addr,
      output o_req_ready, o_rsp_valid, o_read_data, o_err, o_dbg_data
   );
endinterface

// File: rtl/lsu_data_mem_load_extend.sv
// load_extend: selects the addressed byte/half lane of a little-endian
// 32-bit word and sign- or zero-extends it to 32 bits.
//   i_offset   : byte offset within the word (addr[1:0])
//   i_size     : BHW size code
//   i_unsigned : 1 = zero-extend
//   i_word     : raw memory word
//   o_data     : extended load result (word passes through)
module load_extend
   import lsu_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_word,
   output logic [31:0] o_data
);
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = i_word[{i_offset, 3'b000} +: 8];
      h = i_offset[1] ? i_word[31:16] : i_word[15:0];
      case (i_size)
         BHW_BYTE: o_data = {{24{b[7] & ~i_unsigned}}, b};
         BHW_HALF: o_data = {{16{h[15] & ~i_unsigned}}, h};
         default:  o_data = i_word;
      endcase
   end
endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem: byte-addressed little-endian data memory for the MEM stage.
//   i_clk, i_reset : clock, async active-high reset (clears memory too)
//   bus (slave)    : req_valid/req_ready request handshake, addr/data/
//                    read/write/BHW; one-cycle rsp_valid strobe with held
//                    read_data/err; independent registered debug word read.
// Loads respond READ_LATENCY cycles after accept, stores and errors after 1.
module lsu_data_mem
   import lsu_pkg::*;
#(
   parameter int NB_WIDTH     = 32,
   parameter int NB_ADDR      = 9,
   parameter int NB_DATA      = 8,
   parameter int READ_LATENCY = 1
)(
   input  logic            i_clk,
   input  logic            i_reset,
   lsu_data_mem_if.slave   bus
);
   localparam int         DEPTH    = 2**NB_ADDR;
   // WAIT counts down READ_LATENCY-1 edges: loaded with RL-2, sample at 0
   localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

   logic [NB_DATA-1:0]  mem [DEPTH];
   logic [1:0]          state;
   logic [1:0]          lat_cnt;
   logic [NB_ADDR-1:0]  ld_addr;
   logic [2:0]          ld_bhw;
   logic [NB_WIDTH-1:0] rdata_q;
   logic                err_q;
   logic [NB_WIDTH-1:0] dbg_q;

   logic [NB_ADDR-1:0]  addr_eff;
   logic                rd, wr, accept, err_now;
   logic [3:0]          lane_en;
   logic [NB_ADDR-1:0]  rd_addr;
   logic [2:0]          rd_bhw;
   logic [NB_WIDTH-1:0] rd_word, ext_data;

   // upper address bits are dropped, so addresses alias modulo DEPTH
   assign addr_eff = bus.i_mem_addr[NB_ADDR-1:0];
   assign rd       = bus.i_mem_read_CU;
   assign wr       = bus.i_mem_write_CU;
   assign accept   = bus.i_req_valid & bus.o_req_ready & (rd | wr);
   assign err_now  = bhw_err(bus.i_BHW_CU[1:0], addr_eff[1:0]) | (rd & wr);

   assign lane_en[0] = 1'b1;
   assign lane_en[1] = (bus.i_BHW_CU[1:0] != BHW_BYTE);
   assign lane_en[2] = (bus.i_BHW_CU[1:0] == BHW_WORD);
   assign lane_en[3] = (bus.i_BHW_CU[1:0] == BHW_WORD);

   // IDLE samples the live request (READ_LATENCY=1); WAIT uses the captured one
   assign rd_addr = (state == ST_IDLE) ? addr_eff : ld_addr;
   assign rd_bhw  = (state == ST_IDLE) ? bus.i_BHW_CU : ld_bhw;
   assign rd_word = {mem[{rd_addr[NB_ADDR-1:2], 2'b11}], mem[{rd_addr[NB_ADDR-1:2], 2'b10}],
                     mem[{rd_addr[NB_ADDR-1:2], 2'b01}], mem[{rd_addr[NB_ADDR-1:2], 2'b00}]};

   load_extend u_load_extend (
      .i_offset   (rd_addr[1:0]),
      .i_size     (rd_bhw[1:0]),
      .i_unsigned (rd_bhw[BHW_UNSIGNED]),
      .i_word     (rd_word),
      .o_data     (ext_data)
   );

   // byte storage; store lanes commit on the accept edge
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (accept && wr && !err_now) begin
         for (int k = 0; k < 4; k++)
            if (lane_en[k]) mem[addr_eff + NB_ADDR'(k)] <= bus.i_mem_data[NB_DATA*k +: NB_DATA];
      end
   end

   // debug read sees pre-write contents on a same-edge store
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) dbg_q <= '0;
      else         dbg_q <= {mem[{bus.i_dbg_addr, 2'b11}], mem[{bus.i_dbg_addr, 2'b10}],
                             mem[{bus.i_dbg_addr, 2'b01}], mem[{bus.i_dbg_addr, 2'b00}]};
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         lat_cnt <= '0;
         ld_addr <= '0;
         ld_bhw  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               ld_addr <= addr_eff;
               ld_bhw  <= bus.i_BHW_CU;
               if (err_now || wr) begin
                  err_q   <= err_now;
                  rdata_q <= '0;
                  state   <= ST_RESP;
               end else if (READ_LATENCY == 1) begin
                  err_q   <= 1'b0;
                  rdata_q <= ext_data;
                  state   <= ST_RESP;
               end else begin
                  lat_cnt <= CNT_INIT;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: if (lat_cnt == 2'd0) begin
               err_q   <= 1'b0;
               rdata_q <= ext_data;
               state   <= ST_RESP;
            end else begin
               lat_cnt <= lat_cnt - 2'd1;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_req_ready = (state == ST_IDLE) & ~i_reset;
   assign bus.o_rsp_valid = (state == ST_RESP);
   assign bus.o_read_data = rdata_q;
   assign bus.o_err       = err_q;
   assign bus.o_dbg_data  = dbg_q;

endmodule

// File: doc/lsu_data_mem.md
Name: lsu_data_mem

Overview:
Parametrised load/store data memory for the MEM stage. It replaces the single-cycle byte RAM with a request/response handshake, configurable read latency, and alignment/illegal-access error detection. It also adds an independent registered debug word-read port for the debug unit. Byte-addressed and little-endian, with the same i_BHW_CU size/sign encoding as the control unit.

Parameters:
NB_WIDTH, 32, data word width (must be 32)
NB_ADDR, 9, byte-address bits; memory depth is 2^NB_ADDR bytes
NB_DATA, 8, bits per memory cell
READ_LATENCY, 1, cycles from read accept to response (legal range 1..4)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_req_valid  in  1  request present
o_req_ready  out  1  block can accept a request this cycle
i_mem_addr  in  NB_WIDTH  byte address; only [NB_ADDR-1:0] is used
i_mem_data  in  NB_WIDTH  store data, right-aligned
i_mem_read_CU  in  1  load request
i_mem_write_CU  in  1  store request
i_BHW_CU  in  3  [1:0] size: 00 byte, 01 half, 11 word, 10 illegal; [2] 1 = unsigned load
o_rsp_valid  out  1  one-cycle response strobe
o_read_data  out  NB_WIDTH  extended load data; 0 for stores and errors
o_err  out  1  qualified by o_rsp_valid; misaligned or illegal access
i_dbg_addr  in  NB_ADDR-2  debug word index
o_dbg_data  out  NB_WIDTH  registered debug word

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - o_rsp_valid, o_err, o_read_data and o_dbg_data are all 0.
  - o_req_ready is 0 while i_reset=1.
  - All memory bytes are cleared to 0.
  - Any pending read is discarded and produces no response.
- FSM states: IDLE, WAIT, RESP.
  - o_req_ready=1 only in IDLE.
  - Accept = i_req_valid & o_req_ready & (i_mem_read_CU | i_mem_write_CU).
  - A valid request with neither read nor write is ignored and gets no response.
- Error check at accept:
  - o_err=1 if either of the following holds:
    - size is 10; or
    - half access with addr[0]≠0, or word access with addr[1:0]≠0; or
    - read and write are both asserted.
  - On error: no memory change; next state RESP; response has o_err=1 and o_read_data=0.
- Store (accept edge N):
  - Byte lanes are written on edge N.
  - Little-endian: byte at addr holds data[7:0], addr+1 holds [15:8], and so on.
  - Sizes: byte writes 1 lane, half writes 2 lanes, word writes 4 lanes; bit [2] is ignored for stores.
  - Next state RESP; o_rsp_valid=1 in the cycle after N, with o_read_data=0.
- Load (accept edge N):
  - Address and BHW are captured at N.
  - READ_LATENCY=1: memory is sampled at N, next state RESP.
  - READ_LATENCY>1: go to WAIT, down-count READ_LATENCY-1 edges, sample, then RESP.
  - o_rsp_valid is high for exactly one cycle, starting READ_LATENCY cycles after the accept cycle.
  - Extension: signed byte/half sign-extend from bit 7/15; unsigned (bit[2]=1) zero-extend; word is passed through.
- RESP always returns to IDLE on the next edge. Peak throughput is therefore one request per 2 cycles (READ_LATENCY=1).
- Outputs:
  - o_read_data and o_err are registered and held until the next response.
  - o_read_data is 0 for store and error responses.
- Address wrap: upper address bits are ignored, so the address aliases modulo 2^NB_ADDR.
- Debug port:
  - o_dbg_data is the word at byte address {i_dbg_addr,2'b00}, registered with 1-cycle latency.
  - It is independent of the FSM.
  - If a store hits the same word on the same edge, o_dbg_data returns the pre-write data.

Decomposition:
- Package lsu_pkg:
  - BHW size constants BHW_BYTE=2'b00, BHW_HALF=2'b01, BHW_WORD=2'b11.
  - BHW_UNSIGNED bit index 2.
  - FSM state encoding for IDLE/WAIT/RESP.
- Sub-module load_extend: combinational lane select plus sign/zero extension, taking byte-offset, size, unsigned flag and raw word. Instantiated once.

Test Plan:
- SB addr 4, data 0x000000FF, then LB addr 4 → store response with o_err=0; load response 0xFFFFFFFF; LBU addr 4 → 0x000000FF.
- SW addr 12, 0xDEADBEEF → LW 0xDEADBEEF, LHU addr 14 → 0x0000DEAD, LB addr 13 → 0xFFFFFFBE.
- READ_LATENCY=3: accept LW at cycle k → o_rsp_valid exactly at cycle k+3, one cycle wide; o_req_ready low during cycles k+1..k+3.
- SH addr 9, LW addr 6, BHW=3'b010, and read+write both set → o_err=1, data 0, memory unchanged (verified by subsequent LW of the affected words).
- Assert i_reset while in WAIT → no o_rsp_valid, ready returns in IDLE, LW addr 12 reads 0x00000000.
- Store SW addr 20, 0x12345678, while i_dbg_addr=5 → o_dbg_data shows old 0, then 0x12345678 one cycle later.
